half_best_sel: RTL and testbench

- Half-pel refinement stage of the FME datapath; sits directly upstream of the quarter-pel interpolator.
- Streams one current-block pixel plus its 9 half-pel candidate pixels per beat and accumulates 9 SADs.
- Sequentially selects the minimum-SAD candidate, presents it as a 4-bit index, and fires a one-cycle enable pulse.
- The index and pulse drive the interpolator's candidate-select and enable inputs.

---
 rtl/half_best_sel.sv | 154 +++++++++++++++
 tb/tb_half_best_sel.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/half_best_sel.sv
// Half-pel best-candidate selector: accumulates 9 SADs over NPIX beats, then scans for the minimum.
// Optional macro HALF_BEST_CENTER_BIAS_EN scans the centre candidate (4) first so ties favour it.

module half_best_sel_lane #(
    parameter int SAD_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [7:0]       cur,
    input  logic [7:0]       cand,
    output logic [SAD_W-1:0] acc
);
    logic [7:0]   ad;
    logic [SAD_W:0] sum;

    assign ad  = (cur >= cand) ? (cur - cand) : (cand - cur);
    assign sum = {1'b0, acc} + (SAD_W+1)'(ad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= sum[SAD_W] ? '1 : sum[SAD_W-1:0];
    end
endmodule

module half_best_sel #(
    parameter int NPIX  = 16,
    parameter int SAD_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [7:0]       cur_pix,
    input  logic [8:0][7:0]  cand_pix,
    output logic             ready,
    output logic [3:0]       best,
    output logic [SAD_W-1:0] best_sad,
    output logic             quat_en
);
    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [1:0] {IDLE, ACC, CMP, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [3:0]              step_q;
    logic [8:0][SAD_W-1:0]   acc;
    logic                    clr, en, last_beat, take;
    logic [3:0]              cand_idx, idx_q, idx_d;
    logic [SAD_W-1:0]        cand_sad, min_q, min_d;

    assign clr       = (state_q == IDLE) && start;
    assign en        = (state_q == ACC) && pix_valid;
    assign last_beat = en && (cnt_q == CNT_W'(NPIX - 1));

    genvar g;
    generate
        for (g = 0; g < 9; g++) begin : g_lane
            half_best_sel_lane #(.SAD_W(SAD_W)) u_lane (
                .clk  (clk),
                .rst_n(rst_n),
                .clr  (clr),
                .en   (en),
                .cur  (cur_pix),
                .cand (cand_pix[g]),
                .acc  (acc[g])
            );
        end
    endgenerate

    // Maps the compare step to the candidate examined on that step.
    function automatic logic [3:0] scan_cand(input logic [3:0] s);
`ifdef HALF_BEST_CENTER_BIAS_EN
        if (s == 4'd0)
            return 4'd4;
        else if (s <= 4'd4)
            return s - 4'd1;
        else
            return s;
`else
        return s;
`endif
    endfunction

    always_comb begin
        cand_idx = scan_cand(step_q);
        cand_sad = '0;
        for (int k = 0; k < 9; k++)
            if (cand_idx == 4'(k))
                cand_sad = acc[k];
        // Strict less-than keeps the earlier-scanned candidate on ties.
        take  = (step_q == 4'd0) || (cand_sad < min_q);
        min_d = take ? cand_sad : min_q;
        idx_d = take ? cand_idx : idx_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACC;
            ACC:     if (last_beat) state_d = CMP;
            CMP:     if (step_q == 4'd8) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            step_q   <= '0;
            min_q    <= '0;
            idx_q    <= '0;
            best     <= '0;
            best_sad <= '0;
            quat_en  <= 1'b0;
            ready    <= 1'b1;
        end else begin
            if (clr || last_beat)
                cnt_q <= '0;
            else if (en)
                cnt_q <= cnt_q + CNT_W'(1);

            step_q <= (state_q == CMP) ? step_q + 4'd1 : 4'd0;

            if (state_q == CMP) begin
                min_q <= min_d;
                idx_q <= idx_d;
            end

            // Final compare result goes straight to the outputs so they are valid during DONE.
            if (state_q == CMP && step_q == 4'd8) begin
                best     <= idx_d;
                best_sad <= min_d;
            end

            quat_en <= (state_d == DONE);
            ready   <= (state_d == IDLE);
        end
    end
endmodule

// File: tb/tb_half_best_sel.sv
// Directed self-checking bench for half_best_sel (NPIX=16, SAD_W=12).
module tb_half_best_sel;
    localparam int NPIX  = 16;
    localparam int SAD_W = 12;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             pix_valid;
    logic [7:0]       cur_pix;
    logic [8:0][7:0]  cand_pix;
    logic             ready;
    logic [3:0]       best;
    logic [SAD_W-1:0] best_sad;
    logic             quat_en;

    int checks;
    int failures;

    half_best_sel #(.NPIX(NPIX), .SAD_W(SAD_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pix_valid(pix_valid),
        .cur_pix  (cur_pix),
        .cand_pix (cand_pix),
        .ready    (ready),
        .best     (best),
        .best_sad (best_sad),
        .quat_en  (quat_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern modes: 0 unique min @6, 1 tie 2/4, 2 varying per beat, 3 max SAD, 4 min @8, 5 abort filler
    function automatic logic [7:0] cur_of(input int mode, input int b);
        case (mode)
            2:       return 8'(50 + b);
            3, 5:    return 8'd0;
            default: return 8'd100;
        endcase
    endfunction

    function automatic logic [7:0] cand_of(input int mode, input int b, input int k);
        case (mode)
            0:       return (k == 6) ? 8'd100 : 8'(110 + k);
            1:       return (k == 2) ? 8'd102 : (k == 4) ? 8'd98 : 8'd110;
            2:       return (k == 3) ? 8'(49 + b) : 8'(50 + b + 2 * (k + 1));
            3:       return 8'd255;
            4:       return (k == 8) ? 8'd105 : 8'(120 - k);
            default: return 8'd200;
        endcase
    endfunction

    task automatic drive_beat(input int mode, input int b);
        cur_pix = cur_of(mode, b);
        for (int k = 0; k < 9; k++)
            cand_pix[k] = cand_of(mode, b, k);
    endtask

    task automatic run_block(input int mode, input bit stall, input bit start_in_done,
                             input logic [3:0] exp_best, input logic [SAD_W-1:0] exp_sad,
                             input bit chk_hold, input logic [3:0] hold_best,
                             input logic [SAD_W-1:0] hold_sad);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_acc mode=%0d got=%0b exp=0", mode, ready);
        end
        for (int b = 0; b < NPIX; b++) begin
            pix_valid = 1'b1;
            drive_beat(mode, b);
            if (b == 1 && chk_hold) begin
                checks++;
                if (best !== hold_best || best_sad !== hold_sad) begin
                    failures++;
                    $display("FAIL held_result got=%0d/%0d exp=%0d/%0d", best, best_sad, hold_best, hold_sad);
                end
            end
            @(posedge clk); #1;
            if (stall && b < NPIX - 1) begin
                pix_valid = 1'b0;
                start     = 1'b1;
                cur_pix   = 8'hff;
                for (int k = 0; k < 9; k++)
                    cand_pix[k] = 8'($urandom_range(0, 255));
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        pix_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (c < 10) begin
                if (quat_en !== 1'b0) begin
                    failures++;
                    $display("FAIL quat_en_early mode=%0d cycle=%0d got=%0b exp=0", mode, c, quat_en);
                end
            end else begin
                if (quat_en !== 1'b1 || best !== exp_best || best_sad !== exp_sad || ready !== 1'b0) begin
                    failures++;
                    $display("FAIL done_result mode=%0d got qe=%0b best=%0d sad=%0d rdy=%0b exp qe=1 best=%0d sad=%0d rdy=0",
                             mode, quat_en, best, best_sad, ready, exp_best, exp_sad);
                end
                if (start_in_done)
                    start = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (quat_en !== 1'b0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL after_done mode=%0d got qe=%0b rdy=%0b exp qe=0 rdy=1", mode, quat_en, ready);
        end
        if (start_in_done) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== 1'b1) begin
                failures++;
                $display("FAIL start_in_done_restart got rdy=%0b exp=1", ready);
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (ready !== 1'b1 || best !== 4'd0 || best_sad !== '0 || quat_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got rdy=%0b best=%0d sad=%0d qe=%0b exp 1/0/0/0", ready, best, best_sad, quat_en);
        end
    endtask

    task automatic test_unique;
        run_block(0, 1'b0, 1'b0, 4'd6, 12'd0, 1'b0, 4'd0, 12'd0);
    endtask

    task automatic test_reset_abort;
        bit seen;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            pix_valid = 1'b1;
            drive_beat(5, b);
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || best !== 4'd0 || best_sad !== '0 || quat_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort_state got rdy=%0b best=%0d sad=%0d qe=%0b exp 1/0/0/0", ready, best, best_sad, quat_en);
        end
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (quat_en === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL aborted_block_quat_en got=%0b exp=0", seen);
        end
        run_block(0, 1'b0, 1'b0, 4'd6, 12'd0, 1'b0, 4'd0, 12'd0);
    endtask

    task automatic test_tie;
`ifdef HALF_BEST_CENTER_BIAS_EN
        run_block(1, 1'b0, 1'b0, 4'd4, 12'd32, 1'b0, 4'd0, 12'd0);
`else
        run_block(1, 1'b0, 1'b0, 4'd2, 12'd32, 1'b0, 4'd0, 12'd0);
`endif
    endtask

    task automatic test_stall;
        run_block(2, 1'b0, 1'b0, 4'd3, 12'd16, 1'b0, 4'd0, 12'd0);
        run_block(2, 1'b1, 1'b1, 4'd3, 12'd16, 1'b0, 4'd0, 12'd0);
    endtask

    task automatic test_max_sad;
`ifdef HALF_BEST_CENTER_BIAS_EN
        run_block(3, 1'b0, 1'b0, 4'd4, 12'd4080, 1'b0, 4'd0, 12'd0);
`else
        run_block(3, 1'b0, 1'b0, 4'd0, 12'd4080, 1'b0, 4'd0, 12'd0);
`endif
    endtask

    task automatic test_back_to_back;
        run_block(0, 1'b0, 1'b0, 4'd6, 12'd0, 1'b0, 4'd0, 12'd0);
        run_block(4, 1'b0, 1'b0, 4'd8, 12'd80, 1'b1, 4'd6, 12'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        pix_valid = 1'b0;
        cur_pix   = '0;
        cand_pix  = '0;
        #23;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_unique;
        test_reset_abort;
        test_tie;
        test_stall;
        test_max_sad;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
